// File: rtl/sccb_slave.sv
// SCCB (3-wire, OmniVision-style) register-access slave running on the system clock.
// Write: ID, sub-address, data bytes (all to the same address); read: ID, then data from reg_rdata_i.
module sccb_slave #(
   parameter logic [7:0] DEV_ID = 8'h42
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sioc_i,
   input  logic       siod_i,
   output logic       siod_oe_o,
   output logic [7:0] reg_addr_o,
   output logic [7:0] reg_wdata_o,
   output logic       reg_we_o,
   input  logic [7:0] reg_rdata_i,
   output logic       busy_o
);

   typedef enum logic [3:0] {
      IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] sioc_sync_q, siod_sync_q;
   logic       sioc_e_q, siod_e_q, sioc_p_q, siod_p_q;
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       ack_q, ack_d;
   logic       rw_q, rw_d;
   logic       oe_q, oe_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       busy_q, busy_d;
   logic [7:0] rd_q, rd_d;

   logic       sioc_rise_c, sioc_fall_c, start_c, stop_c, last_bit_c, id_match_c;
   logic [7:0] byte_c;

   // Two-flop synchronizers followed by an edge register; all preset to the idle-high bus
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sioc_sync_q <= 2'b11;
         siod_sync_q <= 2'b11;
         sioc_e_q    <= 1'b1;
         siod_e_q    <= 1'b1;
         sioc_p_q    <= 1'b1;
         siod_p_q    <= 1'b1;
      end else begin
         sioc_sync_q <= {sioc_sync_q[0], sioc_i};
         siod_sync_q <= {siod_sync_q[0], siod_i};
         sioc_e_q    <= sioc_sync_q[1];
         siod_e_q    <= siod_sync_q[1];
         sioc_p_q    <= sioc_e_q;
         siod_p_q    <= siod_e_q;
      end
   end

   assign sioc_rise_c = sioc_e_q & ~sioc_p_q;
   assign sioc_fall_c = ~sioc_e_q & sioc_p_q;
   assign start_c     = siod_p_q & ~siod_e_q & sioc_e_q & sioc_p_q;
   assign stop_c      = ~siod_p_q & siod_e_q & sioc_e_q & sioc_p_q;
   assign byte_c      = {shift_q[6:0], siod_e_q};
   assign last_bit_c  = sioc_rise_c && (cnt_q == 3'd7);
   assign id_match_c  = (byte_c[7:1] == DEV_ID[7:1]);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; STOP and START override every state
   always_comb begin
      state_d = state_q;
      if (stop_c) begin
         state_d = IDLE;
      end else if (start_c) begin
         state_d = ID;
      end else begin
         unique case (state_q)
            ID:        if (last_bit_c) state_d = id_match_c ? ID_ACK : IGNORE;
            ID_ACK:    if (sioc_fall_c && ack_q) state_d = rw_q ? RDATA : SUB;
            SUB:       if (last_bit_c) state_d = SUB_ACK;
            SUB_ACK:   if (sioc_fall_c && ack_q) state_d = WDATA;
            WDATA:     if (last_bit_c) state_d = WDATA_ACK;
            WDATA_ACK: if (sioc_fall_c && ack_q) state_d = WDATA;
            RDATA:     if (last_bit_c) state_d = RDATA_NA;
            default:   state_d = state_q;
         endcase
      end
   end

   // Datapath/output next values; ACK slots pull low on the fall after bit 8, release after bit 9
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      rw_d    = rw_q;
      oe_d    = oe_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      busy_d  = busy_q;
      rd_d    = rd_q;
      if (stop_c || start_c) begin
         oe_d  = 1'b0;
         cnt_d = 3'd0;
         ack_d = 1'b0;
         if (stop_c) busy_d = 1'b0;
      end else begin
         unique case (state_q)
            ID, SUB, WDATA: begin
               if (sioc_rise_c) begin
                  shift_d = byte_c;
                  cnt_d   = 3'(cnt_q + 3'd1);
               end
               if (last_bit_c && state_q == ID) begin
                  rw_d   = siod_e_q;
                  busy_d = id_match_c;
               end
               if (last_bit_c && state_q == WDATA) begin
                  wdata_d = byte_c;
                  we_d    = 1'b1;
               end
            end
            ID_ACK, SUB_ACK, WDATA_ACK: begin
               if (sioc_rise_c) ack_d = 1'b1;
               if (sioc_fall_c) begin
                  if (!ack_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d  = 1'b0;
                     ack_d = 1'b0;
                     cnt_d = 3'd0;
                     if (state_q == SUB_ACK) addr_d = shift_q;
                     if (state_q == ID_ACK && rw_q) begin
                        rd_d = reg_rdata_i;
                        oe_d = ~reg_rdata_i[7];
                     end
                  end
               end
            end
            RDATA: begin
               if (sioc_rise_c) cnt_d = 3'(cnt_q + 3'd1);
               if (sioc_fall_c) begin
                  rd_d = {rd_q[6:0], 1'b0};
                  oe_d = ~rd_q[6];
               end
            end
            RDATA_NA: if (sioc_fall_c) oe_d = 1'b0;
            default:  oe_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift_q <= 8'h00;
         cnt_q   <= 3'd0;
         ack_q   <= 1'b0;
         rw_q    <= 1'b0;
         oe_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         rd_q    <= 8'h00;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rw_q    <= rw_d;
         oe_q    <= oe_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         rd_q    <= rd_d;
      end
   end

   assign siod_oe_o   = oe_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_we_o    = we_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Scoreboard bench for sccb_slave: a bus master model pushes expected line bits and
// register writes into queues; independent monitors pop and compare.
module tb_sccb_slave;

   localparam int unsigned Q = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       sioc;
   logic       mst_siod;
   logic       siod_line;
   logic       siod_oe;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic        line_q[$];
   logic [15:0] we_q[$];
   event        bit_ev;
   logic        count_oe = 1'b0;
   int unsigned oe_hits = 0;
   logic        we_prev = 1'b0;

   always #5 clk = ~clk;

   assign siod_line = mst_siod & ~siod_oe;
   assign reg_rdata = (reg_addr == 8'h0A) ? 8'h76 : (reg_addr == 8'h12) ? 8'hC3 : 8'hEE;

   sccb_slave #(.DEV_ID(8'h42)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sioc_i      (sioc),
      .siod_i      (siod_line),
      .siod_oe_o   (siod_oe),
      .reg_addr_o  (reg_addr),
      .reg_wdata_o (reg_wdata),
      .reg_we_o    (reg_we),
      .reg_rdata_i (reg_rdata),
      .busy_o      (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line monitor: compares the wire at each master sample point
   initial begin
      forever begin
         @(bit_ev);
         if (line_q.size() == 0) check("line_unexpected", 32'(siod_line), 32'hx);
         else check("line_bit", 32'(siod_line), 32'(line_q.pop_front()));
      end
   end

   // Register-write monitor
   always @(negedge clk) begin
      if (count_oe && siod_oe) oe_hits <= oe_hits + 1;
      if (!rst && reg_we) begin
         check("we_width", 32'(we_prev), 32'h0);
         if (we_q.size() == 0) begin
            check("we_unexpected", 32'(reg_we), 32'h0);
         end else begin
            logic [15:0] e;
            e = we_q.pop_front();
            check("we_addr", 32'(reg_addr), 32'(e[15:8]));
            check("we_data", 32'(reg_wdata), 32'(e[7:0]));
         end
      end
      we_prev <= reg_we;
   end

   task automatic qw();
      repeat (Q) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic b, input logic exp);
      mst_siod = b;
      qw();
      sioc = 1'b1;
      line_q.push_back(exp);
      qw();
      -> bit_ev;
      qw();
      sioc = 1'b0;
      qw();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic slave_drives, input logic [7:0] exp);
      for (int i = 7; i >= 0; i--) send_bit(slave_drives ? 1'b1 : b[i], exp[i]);
   endtask

   task automatic write_byte(input logic [7:0] b);
      send_byte(b, 1'b0, b);
      send_bit(1'b1, 1'b0);
   endtask

   task automatic nack_byte(input logic [7:0] b);
      send_byte(b, 1'b0, b);
      send_bit(1'b1, 1'b1);
   endtask

   task automatic start();
      mst_siod = 1'b1;
      qw();
      sioc = 1'b1;
      qw();
      mst_siod = 1'b0;
      qw();
      sioc = 1'b0;
      qw();
   endtask

   task automatic stop();
      mst_siod = 1'b0;
      qw();
      sioc = 1'b1;
      qw();
      mst_siod = 1'b1;
      qw();
      qw();
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      sioc = 1'b1;
      mst_siod = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("reset_oe", 32'(siod_oe), 32'h0);
      check("reset_we", 32'(reg_we), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_addr", 32'(reg_addr), 32'h0);
      check("reset_wdata", 32'(reg_wdata), 32'h0);
      rst = 1'b0;
      qw();

      // Plain write 0x80 -> 0x12
      start();
      write_byte(8'h42);
      check("busy_after_id", 32'(busy), 32'h1);
      write_byte(8'h12);
      we_q.push_back(16'h1280);
      write_byte(8'h80);
      stop();
      check("busy_after_stop", 32'(busy), 32'h0);
      check("addr_after_write", 32'(reg_addr), 32'h12);
      check("wdata_after_write", 32'(reg_wdata), 32'h80);

      // Address set then read 0x76 from 0x0A
      start();
      write_byte(8'h42);
      write_byte(8'h0A);
      stop();
      start();
      write_byte(8'h43);
      send_byte(8'h00, 1'b1, 8'h76);
      send_bit(1'b1, 1'b1);
      stop();
      check("addr_after_read", 32'(reg_addr), 32'h0A);

      // Foreign device ID: slave must stay off the bus
      count_oe = 1'b1;
      start();
      nack_byte(8'h60);
      nack_byte(8'h12);
      nack_byte(8'h55);
      stop();
      count_oe = 1'b0;
      check("mismatch_oe_hits", oe_hits, 32'h0);
      check("mismatch_busy", 32'(busy), 32'h0);

      // Abort mid data byte, then a complete write
      start();
      write_byte(8'h42);
      write_byte(8'h12);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      stop();
      check("abort_wdata_kept", 32'(reg_wdata), 32'h80);
      start();
      write_byte(8'h42);
      write_byte(8'h12);
      we_q.push_back(16'h1234);
      write_byte(8'h34);
      stop();

      // Reset while the slave is pulling the ACK low
      start();
      send_byte(8'h42, 1'b0, 8'h42);
      mst_siod = 1'b1;
      qw();
      check("ack_before_reset", 32'(siod_oe), 32'h1);
      rst = 1'b1;
      #1;
      check("reset_mid_ack_oe", 32'(siod_oe), 32'h0);
      check("reset_mid_ack_busy", 32'(busy), 32'h0);
      check("reset_mid_ack_addr", 32'(reg_addr), 32'h0);
      qw();
      rst = 1'b0;
      sioc = 1'b1;
      qw();
      start();
      write_byte(8'h42);
      write_byte(8'h20);
      we_q.push_back(16'h2099);
      write_byte(8'h99);
      stop();

      // Repeated START after the sub-address, then read 0xC3 from 0x12
      start();
      write_byte(8'h42);
      write_byte(8'h12);
      start();
      write_byte(8'h43);
      check("busy_in_read", 32'(busy), 32'h1);
      send_byte(8'h00, 1'b1, 8'hC3);
      send_bit(1'b1, 1'b1);
      stop();
      check("addr_after_rs_read", 32'(reg_addr), 32'h12);
      check("busy_end", 32'(busy), 32'h0);

      qw();
      check("line_queue_drained", line_q.size(), 32'h0);
      check("we_queue_drained", we_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sccb_slave.md
SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 The block SHALL provide parameter DEV_ID, default 8'h42, giving the device address; bit 0 is ignored in the match.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single system clock; every flop is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port sioc_i, input, 1 bit: SCCB clock from the master, asynchronous to clk_i.
REQ-005 The block SHALL have port siod_i, input, 1 bit: SCCB data line as sensed at the pad.
REQ-006 The block SHALL have port siod_oe_o, output, 1 bit: 1 means pull SIOD low; 0 means release it (open-drain, external pull-up).
REQ-007 The block SHALL have port reg_addr_o, output, 8 bits: the latched sub-address.
REQ-008 The block SHALL have port reg_wdata_o, output, 8 bits: the received write data.
REQ-009 The block SHALL have port reg_we_o, output, 1 bit: a one-cycle write strobe.
REQ-010 The block SHALL have port reg_rdata_i, input, 8 bits: register contents at reg_addr_o.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high from an address-matched START until STOP or abort.

Function
REQ-012 sioc_i and siod_i SHALL each pass through a 2-flop synchronizer; an edge register SHALL then detect rising and falling edges.
REQ-013 A START (synced SIOD falls while synced SIOC is high) SHALL enter state ID from any state, which covers repeated START.
REQ-014 A STOP (synced SIOD rises while synced SIOC is high) SHALL enter state IDLE from any state and release SIOD.
REQ-015 States SHALL be IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA and IGNORE; bus activity in IDLE other than START SHALL be ignored.
REQ-016 Incoming bits SHALL be sampled on SIOC rising edges, MSB first, into an 8-bit shift register with a 3-bit bit counter.
REQ-017 After 8 ID bits, if bits [7:1] equal DEV_ID[7:1], the block SHALL go to ID_ACK; otherwise it SHALL go to IGNORE and never drive SIOD until the next START.
REQ-018 In every ACK state, siod_oe_o SHALL go to 1 on the SIOC falling edge after bit 8 and return to 0 on the SIOC falling edge after bit 9.
REQ-019 When ID bit 0 is 0 (write), the block SHALL go to SUB; after SUB_ACK the received byte SHALL be latched into reg_addr_o, and the block SHALL go to WDATA.
REQ-020 After the 8th WDATA bit, reg_wdata_o SHALL load the byte and reg_we_o SHALL pulse for exactly 1 cycle, 4 clk_i cycles after the sioc_i rise at the port; the block SHALL then go to WDATA_ACK.
REQ-021 After WDATA_ACK, further bytes SHALL be ACKed and written to the same reg_addr_o; there is no auto-increment.
REQ-022 When ID bit 0 is 1 (read), reg_rdata_i SHALL be captured on the falling edge that ends ID_ACK.
REQ-023 The read byte SHALL be driven MSB first, with each bit updated on SIOC falling edges, and siod_oe_o = ~bit.
REQ-024 After 8 read bits, SIOD SHALL be released for the 9th (NA) bit; the block SHALL then stay in RDATA_NA until STOP or START.
REQ-025 reg_addr_o SHALL hold its value across transactions until the next SUB byte completes.
REQ-026 A STOP or START in the middle of a byte SHALL discard the partial byte and produce no reg_we_o pulse.
REQ-027 siod_oe_o SHALL change only in response to a detected SIOC falling edge, except when forced to 0 by STOP, START or reset.
REQ-028 Correct operation SHALL require the clk_i frequency to be at least 16x the SCCB bit rate (for example, 24 MHz with 100 kHz SCCB).

Reset
REQ-029 While rst_i is 1, all of the following SHALL hold without waiting for a clock edge:
- state = IDLE
- siod_oe_o = 0, reg_we_o = 0, busy_o = 0
- reg_addr_o = 0, reg_wdata_o = 0
- synchronizers preset to 1 (idle bus)
REQ-030 Reset SHALL be honoured in any state, including mid-ACK and mid-read.
REQ-031 After rst_i deasserts, the block SHALL ignore the bus until a fresh START.

Verification
REQ-032 Write: START, 0x42, 0x12, 0x80, STOP -> three ACK lows; exactly one reg_we_o pulse with reg_addr_o=0x12 and reg_wdata_o=0x80; busy_o low after STOP.
REQ-033 Read: write-phase 0x42, 0x0A, STOP, then START, 0x43 with reg_rdata_i=0x76 -> SIOD carries 0,1,1,1,0,1,1,0; released on the 9th bit; reg_addr_o stays 0x0A.
REQ-034 ID mismatch: START, 0x60, 0x12, 0x55 -> siod_oe_o never 1 and no reg_we_o pulse.
REQ-035 Abort: START, 0x42, 0x12, four bits of 0x80, then STOP -> no reg_we_o pulse; a following full write of 0x34 to 0x12 succeeds.
REQ-036 Reset mid-ACK: assert rst_i while siod_oe_o=1 -> siod_oe_o=0 with no clock edge needed; the next full transaction ACKs normally.
REQ-037 Repeated START after SUB_ACK followed by 0x43 -> enters read; returns reg_rdata_i at the latched reg_addr_o.
